// File: rtl/ddr_read_arbiter_pkg.sv
// Shared definitions for the DDR read arbiter: FSM state encoding, requester
// slot indices, beat geometry and a one-hot to index helper.
package ddr_read_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      STREAM = 2'd2
   } state_t;

   localparam int unsigned NUM_SLOTS = 3;

   localparam logic [1:0] SLOT_BIAS    = 2'd0;
   localparam logic [1:0] SLOT_WEIGHTS = 2'd1;
   localparam logic [1:0] SLOT_DATA    = 2'd2;

   localparam int unsigned BEAT_BYTES = 64;
   localparam int unsigned BEAT_SHIFT = 6;

   // Index of the set bit in a 3-bit one-hot vector (0 when empty).
   function automatic logic [1:0] onehot_to_idx(input logic [2:0] oh);
      logic [1:0] idx;
      idx = 2'd0;
      if (oh[SLOT_WEIGHTS]) idx = SLOT_WEIGHTS;
      if (oh[SLOT_DATA])    idx = SLOT_DATA;
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter, purely combinational.
// Ports:
//   pending    in  3  request vector, one bit per slot
//   last_grant in  2  index of the slot served most recently
//   winner     out 3  one-hot winner; zero when nothing is pending
// The search starts at the slot after last_grant and wraps around.
module rr_arbiter3
   import ddr_read_arbiter_pkg::*;
(
   input  logic [2:0] pending,
   input  logic [1:0] last_grant,
   output logic [2:0] winner
);

   always_comb begin
      winner = 3'b000;
      case (last_grant)
         SLOT_BIAS: begin
            if      (pending[SLOT_WEIGHTS]) winner = 3'b010;
            else if (pending[SLOT_DATA])    winner = 3'b100;
            else if (pending[SLOT_BIAS])    winner = 3'b001;
         end
         SLOT_WEIGHTS: begin
            if      (pending[SLOT_DATA])    winner = 3'b100;
            else if (pending[SLOT_BIAS])    winner = 3'b001;
            else if (pending[SLOT_WEIGHTS]) winner = 3'b010;
         end
         default: begin
            if      (pending[SLOT_BIAS])    winner = 3'b001;
            else if (pending[SLOT_WEIGHTS]) winner = 3'b010;
            else if (pending[SLOT_DATA])    winner = 3'b100;
         end
      endcase
   end

endmodule

// File: rtl/ddr_read_arbiter.sv
// Shares one DDR read engine between three requesters (bias, weights, data).
// Each requester posts a one-cycle (addr, len) request; the arbiter picks a
// winner round-robin, issues one DDR command, then routes the DDR read FIFO
// to the winner until all beats of the transfer have been popped.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   req_st_addr/req_len/req_conf per-slot request (packed 3 slots)
//   req_fifo_req/req_fifo_empty  per-slot FIFO view, routed by grant
//   req_fifo_data                DDR read data broadcast to all slots
//   req_done                     pulse on the last beat of a transfer
//   ddr_st_addr_out/ddr_len/ddr_conf  command to the DDR engine
//   ddr_fifo_empty/ddr_fifo_req/ddr_fifo_data  DDR read FIFO
//   grant, busy, req_drop        status
module ddr_read_arbiter
   import ddr_read_arbiter_pkg::*;
#(
   parameter int unsigned DDR_ADDR_LEN = 32,
   parameter int unsigned SINGLE_LEN   = 24,
   parameter int unsigned DDR_DATA_LEN = 512
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [3*DDR_ADDR_LEN-1:0] req_st_addr,
   input  logic [3*SINGLE_LEN-1:0]   req_len,
   input  logic [2:0]                req_conf,
   input  logic [2:0]                req_fifo_req,
   output logic [2:0]                req_fifo_empty,
   output logic [DDR_DATA_LEN-1:0]   req_fifo_data,
   output logic [2:0]                req_done,
   output logic [DDR_ADDR_LEN-1:0]   ddr_st_addr_out,
   output logic [SINGLE_LEN-1:0]     ddr_len,
   output logic                      ddr_conf,
   input  logic                      ddr_fifo_empty,
   output logic                      ddr_fifo_req,
   input  logic [DDR_DATA_LEN-1:0]   ddr_fifo_data,
   output logic [2:0]                grant,
   output logic                      busy,
   output logic [2:0]                req_drop
);

   localparam int unsigned BEAT_W = SINGLE_LEN - 5;
   localparam int unsigned SUM_W  = SINGLE_LEN + 1;

   state_t                    state, state_nxt;
   logic [2:0]                pending;
   logic [DDR_ADDR_LEN-1:0]   pend_addr [NUM_SLOTS];
   logic [SINGLE_LEN-1:0]     pend_len  [NUM_SLOTS];
   logic [1:0]                last_grant;
   logic [BEAT_W-1:0]         beats_left;
   logic [2:0]                done_zero;

   logic [2:0]                winner;
   logic [1:0]                win_idx;
   logic [1:0]                grant_idx;
   logic [DDR_ADDR_LEN-1:0]   win_addr;
   logic [SINGLE_LEN-1:0]     win_len;
   logic [BEAT_W-1:0]         win_beats;
   logic                      take;
   logic                      finish;
   logic                      route;
   logic                      beat;
   logic                      last_beat;
   logic [2:0]                taken;
   logic [2:0]                conf_ok;
   logic [2:0]                conf_drop;

   rr_arbiter3 u_rr (
      .pending    (pending),
      .last_grant (last_grant),
      .winner     (winner)
   );

   // Winner's latched request and its beat count, rounded up to whole beats.
   always_comb begin
      win_idx   = onehot_to_idx(winner);
      grant_idx = onehot_to_idx(grant);
      win_addr  = pend_addr[win_idx];
      win_len   = pend_len[win_idx];
      win_beats = BEAT_W'((SUM_W'(win_len) + SUM_W'(BEAT_BYTES - 1)) >> BEAT_SHIFT);
   end

   // FIFO routing: only the owner sees the DDR FIFO, and only while beats remain.
   always_comb begin
      route          = (state == STREAM) && (beats_left != '0);
      ddr_fifo_req   = route & req_fifo_req[grant_idx];
      req_fifo_empty = route ? (~grant | {3{ddr_fifo_empty}}) : 3'b111;
      beat           = ddr_fifo_req & ~ddr_fifo_empty;
      last_beat      = beat && (beats_left == BEAT_W'(1));
      req_done       = done_zero | (last_beat ? grant : 3'b000);
      req_fifo_data  = ddr_fifo_data;
   end

   // A slot being granted this cycle may re-request; a busy or waiting slot may not.
   always_comb begin
      taken     = take ? winner : 3'b000;
      conf_ok   = req_conf & ~grant & ~(pending & ~taken);
      conf_drop = req_conf & ~conf_ok;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; a zero-length winner goes straight to STREAM and
   // finishes there without a command.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (|pending) begin
               take      = 1'b1;
               state_nxt = (win_len == '0) ? STREAM : ISSUE;
            end
         end
         ISSUE: state_nxt = STREAM;
         STREAM: begin
            if ((beats_left == '0) || last_beat) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture, command issue and transfer bookkeeping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending         <= 3'b000;
         grant           <= 3'b000;
         busy            <= 1'b0;
         ddr_conf        <= 1'b0;
         done_zero       <= 3'b000;
         req_drop        <= 3'b000;
         beats_left      <= '0;
         last_grant      <= SLOT_DATA;
         ddr_st_addr_out <= '0;
         ddr_len         <= '0;
         for (int i = 0; i < NUM_SLOTS; i++) begin
            pend_addr[i] <= '0;
            pend_len[i]  <= '0;
         end
      end else begin
         ddr_conf  <= 1'b0;
         done_zero <= 3'b000;
         busy      <= (state_nxt != IDLE);
         pending   <= (pending & ~taken) | conf_ok;
         req_drop  <= req_drop | conf_drop;

         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (conf_ok[i]) begin
               pend_addr[i] <= req_st_addr[i*DDR_ADDR_LEN +: DDR_ADDR_LEN];
               pend_len[i]  <= req_len[i*SINGLE_LEN +: SINGLE_LEN];
            end
         end

         if (take) begin
            grant      <= winner;
            beats_left <= win_beats;
            if (win_len != '0) begin
               ddr_conf        <= 1'b1;
               ddr_st_addr_out <= win_addr;
               ddr_len         <= win_len;
            end
         end else if (beat) begin
            beats_left <= beats_left - BEAT_W'(1);
         end

         if (finish) begin
            grant      <= 3'b000;
            last_grant <= grant_idx;
            done_zero  <= (beats_left == '0) ? grant : 3'b000;
         end
      end
   end

endmodule

// File: tb/tb_ddr_read_arbiter.sv
// Bench for ddr_read_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all checked every cycle against a transaction model.
module tb_ddr_read_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned LW = 24;
   localparam int unsigned DW = 512;

   logic            clk;
   logic            rst_n;
   logic [3*AW-1:0] req_st_addr;
   logic [3*LW-1:0] req_len;
   logic [2:0]      req_conf;
   logic [2:0]      req_fifo_req;
   logic [2:0]      req_fifo_empty;
   logic [DW-1:0]   req_fifo_data;
   logic [2:0]      req_done;
   logic [AW-1:0]   ddr_st_addr_out;
   logic [LW-1:0]   ddr_len;
   logic            ddr_conf;
   logic            ddr_fifo_empty;
   logic            ddr_fifo_req;
   logic [DW-1:0]   ddr_fifo_data;
   logic [2:0]      grant;
   logic            busy;
   logic [2:0]      req_drop;

   int n_tests = 0;
   int n_fail  = 0;

   ddr_read_arbiter #(.DDR_ADDR_LEN(AW), .SINGLE_LEN(LW), .DDR_DATA_LEN(DW)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_st_addr     (req_st_addr),
      .req_len         (req_len),
      .req_conf        (req_conf),
      .req_fifo_req    (req_fifo_req),
      .req_fifo_empty  (req_fifo_empty),
      .req_fifo_data   (req_fifo_data),
      .req_done        (req_done),
      .ddr_st_addr_out (ddr_st_addr_out),
      .ddr_len         (ddr_len),
      .ddr_conf        (ddr_conf),
      .ddr_fifo_empty  (ddr_fifo_empty),
      .ddr_fifo_req    (ddr_fifo_req),
      .ddr_fifo_data   (ddr_fifo_data),
      .grant           (grant),
      .busy            (busy),
      .req_drop        (req_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Transaction model: who owns the channel, beats still owed, requests
   // waiting per slot, and the slot served last.
   // ---------------------------------------------------------------------
   bit            m_pend  [3];
   logic [AW-1:0] m_paddr [3];
   logic [LW-1:0] m_plen  [3];
   int            m_owner;
   int            m_last;
   int            m_left;
   bit            m_issue;
   logic [AW-1:0] m_addr;
   logic [LW-1:0] m_len;
   logic [2:0]    m_drop;
   logic [2:0]    m_zdone;

   always @(negedge clk) begin : model
      logic [2:0] e_grant, e_empty, e_done, zd;
      logic       e_freq;
      bit         strm, pop;
      bit         acc [3];
      int         w, idx;

      if (!rst_n) begin
         m_owner = -1; m_last = 2; m_left = 0; m_issue = 1'b0;
         m_addr = '0; m_len = '0; m_drop = '0; m_zdone = '0;
         for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
      end

      strm    = (m_owner >= 0) && !m_issue && (m_left > 0);
      e_grant = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
      e_freq  = strm ? req_fifo_req[m_owner] : 1'b0;
      e_empty = 3'b111;
      if (strm) e_empty[m_owner] = ddr_fifo_empty;
      pop     = e_freq && !ddr_fifo_empty;
      e_done  = m_zdone;
      if (strm && pop && m_left == 1) e_done[m_owner] = 1'b1;

      chk("grant",          64'(grant),           64'(e_grant));
      chk("busy",           64'(busy),            64'(m_owner >= 0));
      chk("ddr_conf",       64'(ddr_conf),        64'(m_issue));
      chk("ddr_addr",       64'(ddr_st_addr_out), 64'(m_addr));
      chk("ddr_len",        64'(ddr_len),         64'(m_len));
      chk("req_fifo_empty", 64'(req_fifo_empty),  64'(e_empty));
      chk("ddr_fifo_req",   64'(ddr_fifo_req),    64'(e_freq));
      chk("req_done",       64'(req_done),        64'(e_done));
      chk("req_drop",       64'(req_drop),        64'(m_drop));
      n_tests++;
      if (req_fifo_data !== ddr_fifo_data) begin
         n_fail++;
         $display("FAIL req_fifo_data: got low 0x%0h, expected low 0x%0h (t=%0t)",
                  req_fifo_data[63:0], ddr_fifo_data[63:0], $time);
      end

      if (rst_n) begin
         w = -1;
         if (m_owner < 0)
            for (int k = 1; k <= 3; k++) begin
               idx = (m_last + k) % 3;
               if (w < 0 && m_pend[idx]) w = idx;
            end
         for (int i = 0; i < 3; i++) begin
            acc[i] = 1'b0;
            if (req_conf[i]) begin
               if (m_owner == i || (m_pend[i] && w != i)) m_drop[i] = 1'b1;
               else acc[i] = 1'b1;
            end
         end
         zd = '0;
         if (m_owner >= 0) begin
            if (m_issue) m_issue = 1'b0;
            else if (m_left == 0) begin
               zd[m_owner] = 1'b1; m_last = m_owner; m_owner = -1;
            end else if (pop) begin
               m_left--;
               if (m_left == 0) begin m_last = m_owner; m_owner = -1; end
            end
         end else if (w >= 0) begin
            m_owner = w;
            m_left  = (int'(m_plen[w]) + 63) / 64;
            m_issue = (m_plen[w] != '0);
            if (m_issue) begin m_addr = m_paddr[w]; m_len = m_plen[w]; end
            m_pend[w] = 1'b0;
         end
         for (int i = 0; i < 3; i++)
            if (acc[i]) begin
               m_pend[i]  = 1'b1;
               m_paddr[i] = req_st_addr[i*AW +: AW];
               m_plen[i]  = req_len[i*LW +: LW];
            end
         m_zdone = zd;
      end
   end

   // ---------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after posedge only.
   // ---------------------------------------------------------------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic negck();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      req_conf       = '0;
      req_fifo_req   = '0;
      ddr_fifo_empty = 1'b1;
      cyc();
      cyc();
      rst_n = 1'b1;
   endtask

   task automatic set_req(input int slot, input logic [AW-1:0] a, input logic [LW-1:0] l);
      req_st_addr[slot*AW +: AW] = a;
      req_len[slot*LW +: LW]     = l;
      req_conf[slot]             = 1'b1;
   endtask

   int            iss_k [4], dn_k [4];
   logic [2:0]    iss_g [4], dn_v [4];
   logic [AW-1:0] iss_a [4];
   int            ni, nd, pops, bias_bad, ndone, nconf, gk, dk, rnd_done;
   bit            done_on4, seen;
   logic [AW-1:0] slot2_addr;

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      rst_n = 1'b0; req_st_addr = '0; req_len = '0; req_conf = '0;
      req_fifo_req = '0; ddr_fifo_empty = 1'b1; ddr_fifo_data = '0;

      // A: single 128-byte request on bias, reset values first
      do_reset();
      negck();
      chk("rst_grant", 64'(grant), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_empty", 64'(req_fifo_empty), 64'h7);
      chk("rst_ddr_len", 64'(ddr_len), 64'h0);
      cyc();
      set_req(0, 32'h1000, 24'd128); req_fifo_req = 3'b001;
      negck(); cyc();
      req_conf = '0;
      negck(); cyc();
      negck();
      chk("A_issue_conf", 64'(ddr_conf), 64'h1);
      chk("A_issue_addr", 64'(ddr_st_addr_out), 64'h1000);
      chk("A_issue_len", 64'(ddr_len), 64'd128);
      chk("A_issue_grant", 64'(grant), 64'h1);
      cyc();
      ddr_fifo_empty = 1'b0;
      negck();
      chk("A_pop1_req", 64'(ddr_fifo_req), 64'h1);
      chk("A_pop1_done", 64'(req_done), 64'h0);
      chk("A_pop1_empty", 64'(req_fifo_empty), 64'h6);
      cyc();
      negck();
      chk("A_pop2_done", 64'(req_done), 64'h1);
      cyc();
      ddr_fifo_empty = 1'b1; req_fifo_req = '0;
      negck();
      chk("A_idle_grant", 64'(grant), 64'h0);
      chk("A_idle_busy", 64'(busy), 64'h0);
      chk("A_hold_len", 64'(ddr_len), 64'd128);
      cyc();

      // B: all three slots at once, 64 bytes each
      do_reset();
      set_req(0, 32'h100, 24'd64); set_req(1, 32'h200, 24'd64); set_req(2, 32'h300, 24'd64);
      req_fifo_req = 3'b111; ddr_fifo_empty = 1'b0;
      ni = 0; nd = 0;
      for (int k = 0; k < 14; k++) begin
         negck();
         if (ddr_conf && ni < 4) begin
            iss_k[ni] = k; iss_g[ni] = grant; iss_a[ni] = ddr_st_addr_out; ni++;
         end
         if (|req_done && nd < 4) begin dn_k[nd] = k; dn_v[nd] = req_done; nd++; end
         cyc();
         if (k == 0) req_conf = '0;
      end
      chk("B_n_issue", 64'(ni), 64'd3);
      chk("B_n_done", 64'(nd), 64'd3);
      if (ni == 3 && nd == 3) begin
         chk("B_first_issue", 64'(iss_k[0]), 64'd2);
         chk("B_grant0", 64'(iss_g[0]), 64'h1);
         chk("B_grant1", 64'(iss_g[1]), 64'h2);
         chk("B_grant2", 64'(iss_g[2]), 64'h4);
         chk("B_addr2", 64'(iss_a[2]), 64'h300);
         chk("B_done0", 64'(dn_v[0]), 64'h1);
         chk("B_done2", 64'(dn_v[2]), 64'h4);
         chk("B_gap1", 64'(iss_k[1] - dn_k[0]), 64'd2);
         chk("B_gap2", 64'(iss_k[2] - dn_k[1]), 64'd2);
      end

      // C: weights 200 bytes, bias holds its pop high throughout
      do_reset();
      set_req(1, 32'hABC0, 24'd200);
      req_fifo_req = 3'b011; ddr_fifo_empty = 1'b1;
      pops = 0; bias_bad = 0; ndone = 0; done_on4 = 1'b0;
      for (int k = 0; k < 25; k++) begin
         negck();
         if (req_fifo_empty[0] !== 1'b1) bias_bad++;
         if (ddr_fifo_req && !ddr_fifo_empty) begin
            pops++;
            if (pops == 4) done_on4 = (req_done == 3'b010);
         end
         if (req_done[1]) ndone++;
         cyc();
         if (k == 0) req_conf = '0;
         ddr_fifo_empty = (k >= 2) ? ((k + 1) % 3 == 0) : 1'b1;
      end
      chk("C_bias_empty", 64'(bias_bad), 64'd0);
      chk("C_pops", 64'(pops), 64'd4);
      chk("C_done_on_4th", 64'(done_on4), 64'h1);
      chk("C_done_count", 64'(ndone), 64'd1);

      // D: data slot requests twice while still waiting
      do_reset();
      set_req(0, 32'h10, 24'd64);
      req_fifo_req = 3'b111; ddr_fifo_empty = 1'b0;
      nconf = 0; ndone = 0; slot2_addr = '0;
      for (int k = 0; k < 20; k++) begin
         negck();
         if (ddr_conf) begin
            nconf++;
            if (grant == 3'b100) slot2_addr = ddr_st_addr_out;
         end
         if (req_done[2]) ndone++;
         cyc();
         req_conf = '0;
         if (k == 0) set_req(2, 32'h3000, 24'd64);
         if (k == 1) set_req(2, 32'h4000, 24'd96);
      end
      chk("D_drop", 64'(req_drop), 64'h4);
      chk("D_conf_count", 64'(nconf), 64'd2);
      chk("D_done2_count", 64'(ndone), 64'd1);
      chk("D_slot2_addr", 64'(slot2_addr), 64'h3000);

      // E: zero-length request on weights
      do_reset();
      set_req(1, 32'h5000, 24'd0);
      req_fifo_req = 3'b111; ddr_fifo_empty = 1'b0;
      nconf = 0; gk = -1; dk = -1;
      for (int k = 0; k < 10; k++) begin
         negck();
         if (ddr_conf) nconf++;
         if (grant == 3'b010 && gk < 0) gk = k;
         if (req_done[1] && dk < 0) dk = k;
         cyc();
         if (k == 0) req_conf = '0;
      end
      chk("E_no_conf", 64'(nconf), 64'd0);
      chk("E_grant_cycle", 64'(gk), 64'd2);
      chk("E_done_after_grant", 64'(dk - gk), 64'd1);

      // F: reset during the 2nd of 4 beats, then a fresh request
      do_reset();
      set_req(0, 32'h2000, 24'd256);
      req_fifo_req = 3'b101; ddr_fifo_empty = 1'b0;
      for (int k = 0; k < 4; k++) begin
         negck(); cyc();
         req_conf = '0;
      end
      chk("F_mid_busy", 64'(busy), 64'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("F_rst_grant", 64'(grant), 64'h0);
      chk("F_rst_busy", 64'(busy), 64'h0);
      chk("F_rst_conf", 64'(ddr_conf), 64'h0);
      chk("F_rst_addr", 64'(ddr_st_addr_out), 64'h0);
      chk("F_rst_len", 64'(ddr_len), 64'h0);
      chk("F_rst_empty", 64'(req_fifo_empty), 64'h7);
      chk("F_rst_freq", 64'(ddr_fifo_req), 64'h0);
      chk("F_rst_done", 64'(req_done), 64'h0);
      negck(); cyc();
      rst_n = 1'b1;
      set_req(2, 32'h6000, 24'd64);
      seen = 1'b0; slot2_addr = '0;
      for (int k = 0; k < 20 && !seen; k++) begin
         negck();
         if (ddr_conf) slot2_addr = ddr_st_addr_out;
         if (req_done[2]) seen = 1'b1;
         cyc();
         req_conf = '0;
      end
      chk("F_after_done", 64'(seen), 64'h1);
      chk("F_after_addr", 64'(slot2_addr), 64'h6000);
      req_fifo_req = '0; ddr_fifo_empty = 1'b1;
      cyc(); cyc();

      // Randomized traffic, with one reset dropped in mid-run
      do_reset();
      rnd_done = 0;
      for (int n = 0; n < 4000; n++) begin
         if (n == 2000) do_reset();
         req_conf = '0;
         for (int i = 0; i < 3; i++) begin
            if ($urandom_range(0, 15) == 0) begin
               int unsigned r;
               logic [LW-1:0] l;
               r = $urandom_range(0, 9);
               if (r == 0)      l = '0;
               else if (r == 1) l = 24'd64;
               else             l = LW'($urandom_range(1, 400));
               set_req(i, $urandom, l);
            end
         end
         req_fifo_req   = 3'($urandom);
         ddr_fifo_empty = ($urandom_range(0, 3) == 0);
         for (int j = 0; j < DW / 32; j++) ddr_fifo_data[j*32 +: 32] = $urandom;
         negck();
         if (|req_done) rnd_done++;
         cyc();
      end
      chk("rnd_some_done", 64'(rnd_done > 20), 64'h1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ddr_read_arbiter.md
DDR_READ_ARBITER -- requirements
Module: ddr_read_arbiter

Interface
REQ-001 Parameter DDR_ADDR_LEN, default 32, DDR byte-address width.
REQ-002 Parameter SINGLE_LEN, default 24, transfer-length width in bytes.
REQ-003 Parameter DDR_DATA_LEN, default 512, read-data beat width; a beat is 64 bytes.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 req_st_addr  in  3*DDR_ADDR_LEN  start address per requester; slot 0 bias, 1 weights, 2 data.
REQ-007 req_len  in  3*SINGLE_LEN  transfer length in bytes per requester.
REQ-008 req_conf  in  3  one-cycle request pulse per requester.
REQ-009 req_fifo_req  in  3  per-requester pop of read data.
REQ-010 req_fifo_empty  out  3  per-requester empty view.
REQ-011 req_fifo_data  out  DDR_DATA_LEN  read data, broadcast to all requesters.
REQ-012 req_done  out  3  one-cycle pulse on the last beat of a requester's transfer.
REQ-013 ddr_st_addr_out  out  DDR_ADDR_LEN  command address to the DDR engine.
REQ-014 ddr_len  out  SINGLE_LEN  command length to the DDR engine.
REQ-015 ddr_conf  out  1  one-cycle command pulse to the DDR engine.
REQ-016 ddr_fifo_empty  in  1  DDR read FIFO empty.
REQ-017 ddr_fifo_req  out  1  DDR read FIFO pop.
REQ-018 ddr_fifo_data  in  DDR_DATA_LEN  DDR read FIFO data.
REQ-019 grant  out  3  one-hot owner of the channel; zero when idle.
REQ-020 busy  out  1  high in any state other than IDLE.
REQ-021 req_drop  out  3  sticky flag per requester; cleared only by reset.

Function
REQ-022 Each req_conf pulse latches that slot's address and length into a pending register and sets its pending bit.
REQ-023 A req_conf on a slot that is already pending or granted is ignored and sets that slot's req_drop bit.
REQ-024 FSM states: IDLE, ISSUE, STREAM.
REQ-025 In IDLE with any pending bit set, the block selects a winner round-robin, searching from the slot after last_grant.
REQ-026 On selection, the block sets grant, clears the winner's pending bit and moves to ISSUE on the next edge.
REQ-027 A req_conf and a grant decision on the same slot in the same cycle: the decision uses the pre-edge pending state, and the new request latches as pending.
REQ-028 ISSUE lasts exactly one cycle: ddr_conf=1 with the winner's latched addr/len; then STREAM.
REQ-029 The beat count is computed as (len+63)>>6, SINGLE_LEN-5 bits wide; no overflow is possible.
REQ-030 A len=0 winner skips ISSUE: req_done pulses, no ddr_conf is issued, and the FSM returns to IDLE one cycle after the grant.
REQ-031 In STREAM, the granted slot sees req_fifo_empty=ddr_fifo_empty and drives ddr_fifo_req=req_fifo_req[g].
REQ-032 In STREAM, non-granted slots see req_fifo_empty=1, and their req_fifo_req is ignored.
REQ-033 A beat is counted when ddr_fifo_req && !ddr_fifo_empty.
REQ-034 On the last beat: req_done[g] pulses the same cycle, last_grant<=g, grant clears, and the next state is IDLE.
REQ-035 After a transfer completes, the earliest new ISSUE is 2 cycles later.
REQ-036 In IDLE and ISSUE, ddr_fifo_req=0 and all req_fifo_empty bits are 1.
REQ-037 A pop on an empty DDR FIFO is not counted and is not forwarded as a valid beat.
REQ-038 ddr_st_addr_out and ddr_len hold their values from ISSUE until the next ISSUE.

Reset
REQ-039 rst_n low forces the following, asynchronously: state IDLE, pending=0, grant=0, busy=0, ddr_conf=0, ddr_fifo_req=0, req_done=0, req_drop=0, beat count 0, last_grant=2 (slot 0 wins first), ddr_st_addr_out=0, ddr_len=0, req_fifo_empty=3'b111.
REQ-040 Reset asserted mid-STREAM abandons the transfer; the DDR FIFO is not flushed by this block.

Structure
REQ-041 A shared package holds the state enum, slot indices BIAS=0/WEIGHTS=1/DATA=2, and BEAT_BYTES=64.
REQ-042 One sub-module, rr_arbiter3, takes (pending, last_grant) and produces a one-hot winner; it is purely combinational.
REQ-043 The datapath is fully registered except the empty/req routing, which is combinational on grant.

Verification
REQ-044 Reset, then req_conf[0] with addr 0x1000 and len 128 -> ISSUE with ddr_st_addr_out=0x1000 and ddr_len=128; 2 beats; req_done[0] on the second pop; state IDLE.
REQ-045 req_conf on all 3 slots in the same cycle, len 64 each -> grants in order 0, 1, 2; each transfer 1 beat; each ISSUE 2 cycles after the previous done.
REQ-046 Weights streaming len=200 (4 beats) with bias fifo_req held high -> bias sees empty=1 throughout; exactly 4 pops; 4th beat asserts done[1].
REQ-047 req_conf[2] twice while slot 2 is pending -> req_drop[2]=1; only one transfer occurs.
REQ-048 len=0 on slot 1 -> no ddr_conf; done[1] pulses 1 cycle after grant.
REQ-049 rst_n low during the 2nd of 4 beats -> all outputs return to reset values immediately; a new request then completes normally.
